// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start + DATA_W data bits (LSB first) [+ even parity] + stop
// from a pre-registered serial line and hands good frames to a one-entry holding buffer.
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN (adds the PARITY state, even parity).
// Ports:
//   clk        rising-edge clock, one serial bit sampled per edge
//   reset      asynchronous, active-high reset
//   din        serial input, idle level 1
//   rx_data    payload of the last accepted frame
//   rx_valid   rx_data holds an unconsumed frame
//   rx_ready   consumer accepts rx_data when rx_valid && rx_ready at an edge
//   frame_err  one-cycle pulse: frame discarded (bad stop or parity)
//   overrun    one-cycle pulse: good frame dropped, buffer full
//   busy       receiver is inside a frame (state other than IDLE)
module serial_frame_rx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd3
  } state_t;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift_q;
  logic               wait_idle;
  logic               last_bit;
  logic               good_c;
  logic               bad_c;
  logic               load_c;
  logic               drop_c;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic               par_ok;
`endif

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a start bit is ignored until the line has returned high after a bad frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!din && !wait_idle) state_nxt = S_DATA;
      S_DATA: if (last_bit) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
        state_nxt = S_PARITY;
`else
        state_nxt = S_STOP;
`endif
      end
`ifdef SERIAL_FRAME_RX_PARITY_EN
      S_PARITY: state_nxt = S_STOP;
`endif
      S_STOP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame verdict at the stop bit and holding-buffer decision
  always_comb begin
    good_c = 1'b0;
    bad_c  = 1'b0;
    if (state == S_STOP) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
      if (din && par_ok) good_c = 1'b1;
      else               bad_c  = 1'b1;
`else
      if (din) good_c = 1'b1;
      else     bad_c  = 1'b1;
`endif
    end
    // Buffer accepts when empty or being drained on this same edge
    load_c = good_c && (!rx_valid || rx_ready);
    drop_c = good_c && rx_valid && !rx_ready;
  end

  // Datapath, holding buffer and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      wait_idle <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_ok    <= 1'b0;
`endif
    end else begin
      frame_err <= bad_c;
      overrun   <= drop_c;
      busy      <= (state_nxt != S_IDLE);

      if (state == S_IDLE) begin
        bit_cnt <= '0;
      end else if (state == S_DATA) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        // Shift right so the first data bit ends up in bit 0
        shift_q <= {din, shift_q[DATA_W-1:1]};
      end

`ifdef SERIAL_FRAME_RX_PARITY_EN
      if (state == S_PARITY) par_ok <= ~((^shift_q) ^ din);
`endif

      if (bad_c)                        wait_idle <= 1'b1;
      else if (state == S_IDLE && din) wait_idle <= 1'b0;

      if (load_c) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam int unsigned DW = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          din;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // Reference: one-entry buffer contents as seen by the consumer
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          last_bad;

  serial_frame_rx #(.DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_err, input logic e_ovr, input logic e_busy);
    chk({tag, ":rx_valid"},  32'(rx_valid),  32'(m_valid));
    chk({tag, ":rx_data"},   32'(rx_data),   32'(m_data));
    chk({tag, ":frame_err"}, 32'(frame_err), 32'(e_err));
    chk({tag, ":overrun"},   32'(overrun),   32'(e_ovr));
    chk({tag, ":busy"},      32'(busy),      32'(e_busy));
  endtask

  // One serial bit; the caller knows whether this bit is a stop bit and whether the frame is good
  task automatic step(input logic d, input logic rdy, input logic is_stop, input logic good,
                      input logic [DW-1:0] pl, input logic e_busy, input string tag);
    logic e_err, e_ovr, drain;
    @(negedge clk);
    din      = d;
    rx_ready = rdy;
    @(posedge clk);
    drain = m_valid && rdy;
    e_err = 1'b0;
    e_ovr = 1'b0;
    if (is_stop && good) begin
      if (!m_valid || drain) begin
        m_data  = pl;
        m_valid = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else begin
      if (is_stop) e_err = 1'b1;
      if (drain)   m_valid = 1'b0;
    end
    #1;
    check_all(tag, e_err, e_ovr, e_busy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, 1'b0, '0, 1'b0, "idle");
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_bad,
                            input logic rdy, input logic rdy_stop, input string tag);
    logic good;
    good = stop_b && !(par_bad && PAR_EN);
    step(1'b0, rdy, 1'b0, 1'b0, '0, 1'b1, {tag, ":start"});
    for (int i = 0; i < DW; i++) step(d[i], rdy, 1'b0, 1'b0, '0, 1'b1, {tag, ":data"});
    if (PAR_EN) step((^d) ^ par_bad, rdy, 1'b0, 1'b0, '0, 1'b1, {tag, ":parity"});
    step(stop_b, rdy_stop, 1'b1, good, d, 1'b0, {tag, ":stop"});
    last_bad = !good;
  endtask

  initial begin
    reset    = 1'b1;
    din      = 1'b1;
    rx_ready = 1'b0;
    m_data   = '0;
    m_valid  = 1'b0;
    last_bad = 1'b0;

    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Single frame, consumer always ready
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, "a5");
    idle(2, 1'b1);

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, "badstop");
    idle(2, 1'b1);

    // Overrun: buffer full, second frame dropped
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, "ovr1");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, "ovr2");
    idle(2, 1'b1);

    // Drain and load on the same edge
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, "sim1");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, "sim2");
    idle(2, 1'b1);

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, "par_ok");
      idle(1, 1'b1);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, "par_bad");
      idle(2, 1'b1);
    end

    // Randomized frames, consumer readiness and gaps
    for (int n = 0; n < 60; n++) begin
      logic [DW-1:0] d;
      logic sb, pb, r, rs;
      int gap;
      d   = DW'($urandom);
      sb  = ($urandom_range(0, 7) != 0);
      pb  = PAR_EN && ($urandom_range(0, 5) == 0);
      r   = 1'($urandom);
      rs  = 1'($urandom);
      send_frame(d, sb, pb, r, rs, "rand");
      gap = $urandom_range(0, 2);
      if (last_bad && gap == 0) gap = 1;
      idle(gap, 1'($urandom));
    end
    idle(2, 1'b1);

    // Reset in mid-frame with a frame held in the buffer
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, "hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, "ff:start");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, "ff:data");
    @(negedge clk);
    reset   = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    #1;
    check_all("midreset", 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("midreset_hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, "after_reset");
    idle(2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
